hex_scan_mux: RTL and testbench

- Time-multiplexed scan controller sitting directly upstream of the per-digit hex-to-7-segment decoder.
- Holds a multi-digit hex value and presents one nibble at a time on `hex`.
- Drives active-low digit enables aligned with the decoder's registered segment output.
- Provides tear-free value updates and optional leading-zero blanking for a shared-segment display.

---
 rtl/hex_scan_mux.sv | 93 +++++++++
 tb/tb_hex_scan_mux.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/hex_scan_mux.sv
// hex_scan_mux: time-multiplexed scan controller for a shared-segment hex display.
// Holds a shadow copy of the incoming value and copies it into the visible value only
// when the scan wraps to digit 0, so a frame never shows a mix of old and new digits.
// The digit enables are registered one cycle behind the digit index. This matches the
// registered hex-to-7-segment decoder downstream, so the segments and the enable of a
// digit change on the same clock edge.
module hex_scan_mux #(
    parameter int DIGITS = 8,
    parameter int DIV    = 50000,
    parameter int DW     = 4*DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DW-1:0]     value,
    input  logic              load,
    input  logic              blank_lz,
    output logic [3:0]        hex,
    output logic [DIGITS-1:0] digit_sel,
    output logic              frame
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    logic [CW-1:0]     divCnt_q,   divCnt_d;
    logic [IW-1:0]     digitIdx_q, digitIdx_d;
    logic [DW-1:0]     shadow_q,   shadow_d;
    logic [DW-1:0]     shown_q,    shown_d;
    logic [DIGITS-1:0] digitSel_q, digitSel_d;
    logic              frame_q,    frame_d;
    logic              divWrap;
    logic              scanWrap;
    logic              allZero;

    // Dwell counter, digit advance, and frame-aligned transfer of the shadow value.
    always_comb begin
        divWrap    = (divCnt_q == DIV_LAST);
        scanWrap   = divWrap && (digitIdx_q == IDX_LAST);
        divCnt_d   = divWrap ? '0 : divCnt_q + CW'(1);
        digitIdx_d = digitIdx_q;
        if (scanWrap) begin
            digitIdx_d = '0;
        end else if (divWrap) begin
            digitIdx_d = digitIdx_q + IW'(1);
        end
        shadow_d = load ? value : shadow_q;
        shown_d  = scanWrap ? shadow_q : shown_q;
        frame_d  = scanWrap;
    end

    // Nibble mux for the current digit and next digit enable, including leading-zero blanking.
    // allZero accumulates from the most significant digit down, so at digit i it says
    // whether every nibble from i up to the top is zero.
    always_comb begin
        allZero    = 1'b1;
        digitSel_d = '1;
        hex        = 4'h0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            allZero = allZero && (shown_q[4*i +: 4] == 4'h0);
            if (digitIdx_q == IW'(i)) begin
                hex = shown_q[4*i +: 4];
                if ((i == 0) || !blank_lz || !allZero) begin
                    digitSel_d[i] = 1'b0;
                end
            end
        end
    end

    // State registers; reset overrides load and all counting.
    always_ff @(posedge clk) begin
        if (rst) begin
            divCnt_q   <= '0;
            digitIdx_q <= '0;
            shadow_q   <= '0;
            shown_q    <= '0;
            digitSel_q <= '1;
            frame_q    <= 1'b0;
        end else begin
            divCnt_q   <= divCnt_d;
            digitIdx_q <= digitIdx_d;
            shadow_q   <= shadow_d;
            shown_q    <= shown_d;
            digitSel_q <= digitSel_d;
            frame_q    <= frame_d;
        end
    end

    assign digit_sel = digitSel_q;
    assign frame     = frame_q;

endmodule

// File: tb/tb_hex_scan_mux.sv
// tb_hex_scan_mux: scoreboard bench for hex_scan_mux.
// The main instance (8 digits, 4 cycles per digit) is compared with a cycle-position
// model: one entry of expected outputs is queued per clock, and a monitor pops and compares.
// The second instance (4 digits) drives a registered hex-to-7-segment decoder. It is
// checked so that the lit digit and the segment pattern always belong to the same digit.
module tb_hex_scan_mux;

    localparam int DIGITS = 8;
    localparam int DIV    = 4;
    localparam int PERIOD = DIGITS * DIV;

    typedef struct packed {
        logic [3:0] hex;
        logic [7:0] digitSel;
        logic       frame;
    } expect_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] value;
    logic        load;
    logic        blank_lz;
    logic [3:0]  hex;
    logic [7:0]  digit_sel;
    logic        frame;

    logic        rst2;
    logic [3:0]  hex2;
    logic [3:0]  digitSel2;
    logic        frame2;
    logic [6:0]  seg2;

    int checks = 0;
    int errors = 0;
    bit decDone = 1'b0;

    expect_t     scoreQ[$];
    int unsigned mPos;
    logic [31:0] mShadow;
    logic [31:0] mShown;

    always #5 clk = ~clk;

    hex_scan_mux #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .value(value), .load(load), .blank_lz(blank_lz),
        .hex(hex), .digit_sel(digit_sel), .frame(frame)
    );

    hex_scan_mux #(.DIGITS(4), .DIV(3)) dut2 (
        .clk(clk), .rst(rst2), .value(16'h0F1E), .load(1'b1), .blank_lz(1'b0),
        .hex(hex2), .digit_sel(digitSel2), .frame(frame2)
    );

    function automatic logic [6:0] hexToSeg(input logic [3:0] h);
        case (h)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    // Stand-in for the downstream decoder: one cycle of registered latency.
    always_ff @(posedge clk) seg2 <= hexToSeg(hex2);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one clock's inputs and queue the outputs expected after the next posedge.
    // mPos is the position in the scan (digit = mPos / DIV), counted from reset release.
    task automatic applyStimulus(input logic r, input logic ld, input logic [31:0] v, input logic bl);
        expect_t e;
        int d;
        @(negedge clk);
        rst = r; load = ld; value = v; blank_lz = bl;
        if (r) begin
            mPos = 0; mShadow = '0; mShown = '0;
            e.digitSel = 8'hFF; e.frame = 1'b0; e.hex = 4'h0;
        end else begin
            d = int'(mPos / DIV);
            e.digitSel = 8'hFF;
            if (d == 0 || !bl || (mShown >> (4*d)) != 0) e.digitSel[d] = 1'b0;
            e.frame = (mPos == PERIOD - 1);
            if (e.frame) mShown = mShadow;
            if (ld) mShadow = v;
            mPos = (mPos + 1) % PERIOD;
            e.hex = 4'((mShown >> (4*(mPos / DIV))) & 32'hF);
        end
        scoreQ.push_back(e);
    endtask

    task automatic idle(input int n, input logic bl);
        for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 32'h0, bl);
    endtask

    task automatic idleUntilWrapEdge(input logic bl);
        for (int c = 0; c < PERIOD && mPos != PERIOD - 1; c++) applyStimulus(1'b0, 1'b0, 32'h0, bl);
    endtask

    // Monitor: compare the queued expectation one step after each active edge.
    initial begin
        expect_t e;
        forever begin
            @(posedge clk);
            #1;
            if (scoreQ.size() > 0) begin
                e = scoreQ.pop_front();
                checkOutput("hex", 32'(hex), 32'(e.hex));
                checkOutput("digit_sel", 32'(digit_sel), 32'(e.digitSel));
                checkOutput("frame", 32'(frame), 32'(e.frame));
            end
        end
    end

    // Decoder alignment: the lit digit and the registered segments must agree every cycle.
    initial begin
        int framesSeen;
        int litCount;
        int litIdx;
        logic [15:0] shownVal;
        shownVal = 16'h0F1E;
        rst2 = 1'b1;
        repeat (3) @(negedge clk);
        rst2 = 1'b0;
        framesSeen = 0;
        for (int c = 0; c < 200 && framesSeen < 2; c++) begin
            @(negedge clk);
            if (frame2) framesSeen++;
        end
        checkOutput("dec_frames", 32'(framesSeen), 32'd2);
        repeat (48) begin
            @(negedge clk);
            litCount = 0;
            litIdx = 0;
            for (int i = 0; i < 4; i++) begin
                if (!digitSel2[i]) begin
                    litCount++;
                    litIdx = i;
                end
            end
            checkOutput("dec_lit_count", 32'(litCount), 32'd1);
            checkOutput("dec_seg", 32'(seg2), 32'(hexToSeg(4'((shownVal >> (4*litIdx)) & 16'hF))));
        end
        decDone = 1'b1;
    end

    // Directed scenarios followed by a randomized run.
    initial begin
        logic bl;
        logic [31:0] rv;
        rst = 1'b1; load = 1'b0; value = '0; blank_lz = 1'b0;

        repeat (3) applyStimulus(1'b1, 1'b0, 32'h0, 1'b0);
        idle(40, 1'b0);

        idle(10, 1'b0);
        applyStimulus(1'b0, 1'b1, 32'h12345678, 1'b0);
        idle(70, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'h0BADF00D, 1'b0);
        idleUntilWrapEdge(1'b0);
        applyStimulus(1'b0, 1'b1, 32'hAAAAAAAA, 1'b0);
        idle(70, 1'b0);

        applyStimulus(1'b0, 1'b1, 32'h00000A05, 1'b1);
        idle(70, 1'b1);
        applyStimulus(1'b0, 1'b1, 32'h00000000, 1'b1);
        idle(70, 1'b1);

        applyStimulus(1'b0, 1'b1, 32'hFEDCBA98, 1'b0);
        idle(40, 1'b0);
        for (int c = 0; c < PERIOD && (mPos / DIV) != 5; c++) applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
        applyStimulus(1'b1, 1'b1, 32'h55555555, 1'b0);
        idle(70, 1'b0);

        bl = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 31) == 0) bl = ~bl;
            rv = $urandom >> (4 * $urandom_range(0, 8));
            applyStimulus($urandom_range(0, 199) == 0, $urandom_range(0, 15) == 0, rv, bl);
        end

        for (int c = 0; c < 10 && scoreQ.size() > 0; c++) @(negedge clk);
        checkOutput("queue_drained", 32'(scoreQ.size()), 32'd0);
        for (int c = 0; c < 1000 && !decDone; c++) @(negedge clk);
        checkOutput("dec_done", 32'(decDone), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
